rf_port_scheduler: RTL and testbench

//  Shares the 32x32 register file's single write port and its reg1 index between three writeback

---
 rtl/rf_port_scheduler.sv | 141 ++++++++++++++
 tb/tb_rf_port_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rf_port_scheduler.sv
// Arbitrates the register file's single write port between ALU, LOAD and LINK writeback and the
// decode operand read. Optional same-cycle r31 forwarding of link data: RF_LINK_BYPASS_EN.
module rf_port_scheduler #(
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 5,
    parameter int MAX_RD_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [IDX_W-1:0]  alu_idx,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ld_valid,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              lnk_valid,
    input  logic [DATA_W-1:0] lnk_data,
    output logic              lnk_ready,
    input  logic              rd_req,
    input  logic [IDX_W-1:0]  rd_idx1,
    input  logic [IDX_W-1:0]  rd_idx2,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_val1,
    output logic [DATA_W-1:0] rd_val2,
    output logic [IDX_W-1:0]  rf_reg1_index,
    output logic [IDX_W-1:0]  rf_reg2_index,
    output logic [1:0]        rf_reg_write,
    output logic [DATA_W-1:0] rf_data_write,
    input  logic [DATA_W-1:0] rf_reg1_value,
    input  logic [DATA_W-1:0] rf_reg2_value
);

    localparam int WAIT_W = (MAX_RD_WAIT < 1) ? 1 : $clog2(MAX_RD_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_RD_WAIT);
    localparam logic [IDX_W-1:0] LINK_IDX = IDX_W'(31);

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_LINK = 2'd2
    } src_e;

    src_e              rr_ptr;
    src_e              rr_next;
    src_e              winner;
    src_e              cand;
    logic              grant_any;
    logic              force_rd;
    logic [2:0]        eligible;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;

    function automatic src_e next_src(input src_e s);
        case (s)
            SRC_ALU:  return SRC_LOAD;
            SRC_LOAD: return SRC_LINK;
            default:  return SRC_ALU;
        endcase
    endfunction

    // A starved read locks out ALU/LOAD; LINK still goes because it uses the r31 write code.
    always_comb begin
        force_rd  = rd_req && (wait_cnt == WAIT_MAX);
        eligible  = {lnk_valid, ld_valid & ~force_rd, alu_valid & ~force_rd};
        grant_any = 1'b0;
        winner    = rr_ptr;
        cand      = rr_ptr;
        for (int k = 0; k < 3; k++) begin
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                winner    = cand;
            end
            cand = next_src(cand);
        end
    end

    always_comb begin
        alu_ready     = 1'b0;
        ld_ready      = 1'b0;
        lnk_ready     = 1'b0;
        rd_gnt        = 1'b0;
        rf_reg_write  = 2'b00;
        rf_data_write = '0;
        rf_reg1_index = rd_idx1;
        rf_reg2_index = rd_idx2;
        rd_val1       = rf_reg1_value;
        rd_val2       = rf_reg2_value;
        rr_next       = rr_ptr;
        if (rst) begin
            rd_gnt = rd_req;
            if (grant_any) begin
                rr_next = next_src(winner);
                case (winner)
                    SRC_ALU: begin
                        alu_ready     = 1'b1;
                        rf_reg_write  = 2'b10;
                        rf_reg1_index = alu_idx;
                        rf_data_write = alu_data;
                        rd_gnt        = 1'b0;
                    end
                    SRC_LOAD: begin
                        ld_ready      = 1'b1;
                        rf_reg_write  = 2'b10;
                        rf_reg1_index = ld_idx;
                        rf_data_write = ld_data;
                        rd_gnt        = 1'b0;
                    end
                    default: begin
                        lnk_ready     = 1'b1;
                        rf_reg_write  = 2'b01;
                        rf_data_write = lnk_data;
`ifdef RF_LINK_BYPASS_EN
                        if (rd_req && rd_idx1 == LINK_IDX) rd_val1 = lnk_data;
                        if (rd_req && rd_idx2 == LINK_IDX) rd_val2 = lnk_data;
`endif
                    end
                endcase
            end
        end
    end

    always_comb begin
        if (rd_req && !rd_gnt)
            wait_next = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
        else
            wait_next = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= SRC_ALU;
            wait_cnt <= '0;
        end else begin
            rr_ptr   <= rr_next;
            wait_cnt <= wait_next;
        end
    end

endmodule

// File: tb/tb_rf_port_scheduler.sv
// Scoreboard bench for rf_port_scheduler with a behavioural 32x32 register file attached.
module tb_rf_port_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, ld_valid, lnk_valid, rd_req;
    logic [4:0]  alu_idx, ld_idx, rd_idx1, rd_idx2;
    logic [31:0] alu_data, ld_data, lnk_data;
    logic        alu_ready, ld_ready, lnk_ready, rd_gnt;
    logic [31:0] rd_val1, rd_val2;
    logic [4:0]  rf_reg1_index, rf_reg2_index;
    logic [1:0]  rf_reg_write;
    logic [31:0] rf_data_write, rf_reg1_value, rf_reg2_value;

    logic [31:0] rf_mem [32];
    logic        rf_load;

    typedef struct {
        string       name;
        logic        alu_r, ld_r, lnk_r, gnt;
        logic [1:0]  wr;
        logic        chk_idx;
        logic [4:0]  idx;
        logic [31:0] wdata;
        logic        chk_val;
        logic [31:0] v1, v2;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rf_port_scheduler dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_idx(alu_idx), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data), .ld_ready(ld_ready),
        .lnk_valid(lnk_valid), .lnk_data(lnk_data), .lnk_ready(lnk_ready),
        .rd_req(rd_req), .rd_idx1(rd_idx1), .rd_idx2(rd_idx2),
        .rd_gnt(rd_gnt), .rd_val1(rd_val1), .rd_val2(rd_val2),
        .rf_reg1_index(rf_reg1_index), .rf_reg2_index(rf_reg2_index),
        .rf_reg_write(rf_reg_write), .rf_data_write(rf_data_write),
        .rf_reg1_value(rf_reg1_value), .rf_reg2_value(rf_reg2_value)
    );

    // Register file: r31 starts at zero, every other register at 0x1000_0000 + index.
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++)
                rf_mem[i] <= (i == 31) ? 32'h0 : 32'h1000_0000 + 32'(i);
        end else if (rf_reg_write == 2'b10) begin
            rf_mem[rf_reg1_index] <= rf_data_write;
        end else if (rf_reg_write == 2'b01) begin
            rf_mem[31] <= rf_data_write;
        end
    end

    assign rf_reg1_value = rf_mem[rf_reg1_index];
    assign rf_reg2_value = rf_mem[rf_reg2_index];

    task automatic checkOutput(input string name, input string field,
                               input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s.%s actual=0x%08h required=0x%08h", name, field, act, req);
        end
    endtask

    task automatic applyStimulus(input logic r,
                                 input logic av, input logic [4:0] ai, input logic [31:0] ad,
                                 input logic lv, input logic [4:0] li, input logic [31:0] ldd,
                                 input logic kv, input logic [31:0] kd,
                                 input logic rq, input logic [4:0] i1, input logic [4:0] i2);
        @(posedge clk);
        #1;
        rst = r;
        alu_valid = av; alu_idx = ai; alu_data = ad;
        ld_valid = lv;  ld_idx = li;  ld_data = ldd;
        lnk_valid = kv; lnk_data = kd;
        rd_req = rq;    rd_idx1 = i1; rd_idx2 = i2;
    endtask

    task automatic pushExpected(input string name,
                                input logic ar, input logic lr, input logic kr, input logic g,
                                input logic [1:0] wr, input logic ci, input logic [4:0] idx,
                                input logic [31:0] wd, input logic cv,
                                input logic [31:0] v1, input logic [31:0] v2);
        exp_t e;
        e.name = name; e.alu_r = ar; e.ld_r = lr; e.lnk_r = kr; e.gnt = g;
        e.wr = wr; e.chk_idx = ci; e.idx = idx; e.wdata = wd;
        e.chk_val = cv; e.v1 = v1; e.v2 = v2;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e.name, "alu_ready", 32'(alu_ready), 32'(e.alu_r));
            checkOutput(e.name, "ld_ready", 32'(ld_ready), 32'(e.ld_r));
            checkOutput(e.name, "lnk_ready", 32'(lnk_ready), 32'(e.lnk_r));
            checkOutput(e.name, "rd_gnt", 32'(rd_gnt), 32'(e.gnt));
            checkOutput(e.name, "rf_reg_write", 32'(rf_reg_write), 32'(e.wr));
            checkOutput(e.name, "rf_data_write", rf_data_write, e.wdata);
            if (e.chk_idx)
                checkOutput(e.name, "rf_reg1_index", 32'(rf_reg1_index), 32'(e.idx));
            if (e.chk_val) begin
                checkOutput(e.name, "rd_val1", rd_val1, e.v1);
                checkOutput(e.name, "rd_val2", rd_val2, e.v2);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    localparam logic [31:0] BEEF = 32'hDEAD_BEEF;
`ifdef RF_LINK_BYPASS_EN
    localparam logic [31:0] SAME_CYCLE_R31 = BEEF;
`else
    localparam logic [31:0] SAME_CYCLE_R31 = 32'h0;
`endif

    initial begin
        rst = 1'b0; rf_load = 1'b1;
        alu_valid = 1'b1; alu_idx = 5'd7; alu_data = 32'hA1;
        ld_valid = 1'b1;  ld_idx = 5'd9;  ld_data = 32'hB1;
        lnk_valid = 1'b1; lnk_data = 32'hC1;
        rd_req = 1'b0; rd_idx1 = 5'd0; rd_idx2 = 5'd0;
        @(posedge clk);
        #1 rf_load = 1'b0;

        // Reset with every source requesting, then the first grant after release.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, 7, 32'hA1, 1, 9, 32'hB1, 1, 32'hC1, 0, 0, 0);
            pushExpected("reset_hold", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        end
        applyStimulus(1, 1, 7, 32'hA1, 1, 9, 32'hB1, 1, 32'hC1, 0, 0, 0);
        pushExpected("first_grant", 1, 0, 0, 0, 2'b10, 1, 7, 32'hA1, 0, 0, 0);

        // Link write plus same-cycle read of r31, then the committed value.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, BEEF, 1, 5, 31);
        pushExpected("link_r31_same", 0, 0, 1, 1, 2'b01, 1, 5, BEEF, 1, 32'h1000_0005, SAME_CYCLE_R31);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 31);
        pushExpected("link_r31_next", 0, 0, 0, 1, 2'b00, 1, 5, 0, 1, 32'h1000_0005, BEEF);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 32'h1234, 1, 3, 4);
        pushExpected("link_with_read", 0, 0, 1, 1, 2'b01, 1, 3, 32'h1234, 1, 32'h1000_0003, 32'h1000_0004);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pushExpected("idle", 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);

        // ALU and LOAD alternate.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 8, 32'hA8, 1, 9, 32'hB9, 0, 0, 0, 0, 0);
            if (i % 2 == 0)
                pushExpected("rr_alu", 1, 0, 0, 0, 2'b10, 1, 8, 32'hA8, 0, 0, 0);
            else
                pushExpected("rr_load", 0, 1, 0, 0, 2'b10, 1, 9, 32'hB9, 0, 0, 0);
        end

        // Continuous ALU traffic starves the read for four cycles, then the read is forced.
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(1, 1, 10, 32'hC10, 0, 0, 0, 0, 0, 1, 1, 2);
            if (c % 5 == 0)
                pushExpected("starve_forced", 0, 0, 0, 1, 2'b00, 1, 1, 0, 1, 32'h1000_0001, 32'h1000_0002);
            else
                pushExpected("starve_alu", 1, 0, 0, 0, 2'b10, 1, 10, 32'hC10, 0, 0, 0);
        end

        // Reset after a LOAD grant restarts both the pointer and the wait counter.
        applyStimulus(1, 1, 11, 32'hD11, 1, 12, 32'hD12, 1, 32'hD13, 1, 1, 2);
        pushExpected("pre_reset_load", 0, 1, 0, 0, 2'b10, 1, 12, 32'hD12, 0, 0, 0);
        applyStimulus(0, 1, 11, 32'hD11, 1, 12, 32'hD12, 1, 32'hD13, 1, 1, 2);
        pushExpected("mid_reset", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 11, 32'hD11, 1, 12, 32'hD12, 1, 32'hD13, 1, 1, 2);
        pushExpected("post_reset_alu", 1, 0, 0, 0, 2'b10, 1, 11, 32'hD11, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1, 1, 11, 32'hE11, 0, 0, 0, 0, 0, 1, 1, 2);
            if (c == 3)
                pushExpected("post_reset_forced", 0, 0, 0, 1, 2'b00, 1, 1, 0, 1, 32'h1000_0001, 32'h1000_0002);
            else
                pushExpected("post_reset_wait", 1, 0, 0, 0, 2'b10, 1, 11, 32'hE11, 0, 0, 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        pushExpected("final_idle", 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        checkOutput("drain", "queue_left", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
